// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the E-stage forward-select encodings and the mult/div FSM state type,
// plus a helper that turns M/W match flags into a forward select.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from writeback stage
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory stage

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_t;

    // M is the younger producer, so it wins when both stages match.
    function automatic logic [1:0] fwd_e_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_M;
        else if (hit_w) return FWD_W;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_fsm.sv
// Multi-cycle (mult/div) occupancy tracker: IDLE -> BUSY -> DONE -> IDLE.
// Ports: clk, rst (async high), start (op enters E), abort (exception in M),
//        busy (E must hold), ready (result valid this cycle).
// Latency: busy on the start cycle plus MD_LAT-2 BUSY cycles, ready for one
//          DONE cycle, so the op occupies E for exactly MD_LAT cycles.
module md_busy_fsm
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic ready
);

    // Number of cycles spent in BUSY between the start cycle and DONE.
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MD_LAT - 2);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        ready       = 1'b0;
        case (r_state)
            IDLE: begin
                // A start squashed by an exception (or seen during reset)
                // never begins, so it must not stall the pipe either.
                if (start && !abort && !rst) begin
                    busy = 1'b1;
                    if (LOAD == '0) begin
                        // Two-cycle op: start cycle then straight to result.
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = LOAD;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                // Counter holds the BUSY cycles still owed, this one included.
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ready       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/branch stalls,
// multi-cycle mult/div holds and exception flushes.
// Ports: D/E source IDs, E/M/W destination IDs and write flags in; forward
//        selects, per-stage stall/flush and mult/div busy/ready out.
// All outputs are combinational from inputs and the registered md FSM state.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              mdstartE,
    input  logic              exceptM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mdbusy,
    output logic              mdready
);

    logic w_rsD_nz, w_rtD_nz, w_rsE_nz, w_rtE_nz;
    logic w_wrE_nz, w_wrM_nz;
    logic w_lwstall, w_brstall;
    logic w_br_rs_hit, w_br_rt_hit;
    logic w_md_busy, w_md_ready;

    // Register 0 is hardwired zero: never forward or stall on it.
    assign w_rsD_nz = (rsD != '0);
    assign w_rtD_nz = (rtD != '0);
    assign w_rsE_nz = (rsE != '0);
    assign w_rtE_nz = (rtE != '0);
    assign w_wrE_nz = (writeregE != '0);
    assign w_wrM_nz = (writeregM != '0);

    assign forwardAE = fwd_e_sel(w_rsE_nz && regwriteM && (rsE == writeregM),
                                 w_rsE_nz && regwriteW && (rsE == writeregW));
    assign forwardBE = fwd_e_sel(w_rtE_nz && regwriteM && (rtE == writeregM),
                                 w_rtE_nz && regwriteW && (rtE == writeregW));

    assign forwardAD = w_rsD_nz && regwriteM && (rsD == writeregM);
    assign forwardBD = w_rtD_nz && regwriteM && (rtD == writeregM);

    assign w_lwstall = memtoregE && w_wrE_nz &&
                       ((writeregE == rsD) || (writeregE == rtD));

    // The D-stage comparator needs its operands now: an ALU result still in E
    // or a load still in M cannot be forwarded in time.
    assign w_br_rs_hit = (regwriteE && w_wrE_nz && (writeregE == rsD)) ||
                         (memtoregM && w_wrM_nz && (writeregM == rsD));
    assign w_br_rt_hit = (regwriteE && w_wrE_nz && (writeregE == rtD)) ||
                         (memtoregM && w_wrM_nz && (writeregM == rtD));
    // jr reads only rs.
    assign w_brstall = (branchD && (w_br_rs_hit || w_br_rt_hit)) ||
                       (jrD && w_br_rs_hit);

    md_busy_fsm #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_busy_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (mdstartE),
        .abort (exceptM),
        .busy  (w_md_busy),
        .ready (w_md_ready)
    );

    assign mdbusy  = w_md_busy;
    assign mdready = w_md_ready;

    // Priority: reset/exception flush > mult/div hold > load/branch stall.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst || exceptM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (w_md_busy) begin
            // Hold F/D/E around the multi-cycle op and bubble into M.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (w_lwstall || w_brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic              rst;
        logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
        logic [REG_AW-1:0] writeregE, writeregM, writeregW;
        logic              regwriteE, regwriteM, regwriteW;
        logic              memtoregE, memtoregM;
        logic              branchD, jrD, mdstartE, exceptM;
    } in_t;

    typedef struct packed {
        logic [1:0] fae, fbe;
        logic       fad, fbd;
        logic       sf, sd, se;
        logic       fld, fle, flm;
        logic       busy, ready;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REG_AW-1:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
    logic [REG_AW-1:0] writeregE = '0, writeregM = '0, writeregW = '0;
    logic              regwriteE = 1'b0, regwriteM = 1'b0, regwriteW = 1'b0;
    logic              memtoregE = 1'b0, memtoregM = 1'b0;
    logic              branchD = 1'b0, jrD = 1'b0, mdstartE = 1'b0, exceptM = 1'b0;
    logic [1:0]        forwardAE, forwardBE;
    logic              forwardAD, forwardBD;
    logic              stallF, stallD, stallE, flushD, flushE, flushM;
    logic              mdbusy, mdready;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .mdstartE(mdstartE), .exceptM(exceptM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .mdbusy(mdbusy), .mdready(mdready)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference behaviour; xb/xr are the mult/div busy/ready the scenario expects.
    function automatic exp_t model(input in_t v, input logic xb, input logic xr);
        exp_t e;
        logic lw, br_rs, br_rt, br;
        e = '0;
        if (v.rsE != 0 && v.regwriteM && v.rsE == v.writeregM)      e.fae = 2'b10;
        else if (v.rsE != 0 && v.regwriteW && v.rsE == v.writeregW) e.fae = 2'b01;
        if (v.rtE != 0 && v.regwriteM && v.rtE == v.writeregM)      e.fbe = 2'b10;
        else if (v.rtE != 0 && v.regwriteW && v.rtE == v.writeregW) e.fbe = 2'b01;
        e.fad = (v.rsD != 0) && v.regwriteM && (v.rsD == v.writeregM);
        e.fbd = (v.rtD != 0) && v.regwriteM && (v.rtD == v.writeregM);
        lw    = v.memtoregE && (v.writeregE != 0) &&
                (v.writeregE == v.rsD || v.writeregE == v.rtD);
        br_rs = (v.regwriteE && v.writeregE != 0 && v.writeregE == v.rsD) ||
                (v.memtoregM && v.writeregM != 0 && v.writeregM == v.rsD);
        br_rt = (v.regwriteE && v.writeregE != 0 && v.writeregE == v.rtD) ||
                (v.memtoregM && v.writeregM != 0 && v.writeregM == v.rtD);
        br    = (v.branchD && (br_rs || br_rt)) || (v.jrD && br_rs);
        e.busy  = xb;
        e.ready = xr;
        if (v.rst || v.exceptM) begin
            e.fld = 1'b1; e.fle = 1'b1; e.flm = 1'b1;
        end else if (xb) begin
            e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.flm = 1'b1;
        end else if (lw || br) begin
            e.sf = 1'b1; e.sd = 1'b1; e.fle = 1'b1;
        end
        return e;
    endfunction

    task automatic apply(input in_t v);
        rst = v.rst;
        rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
        writeregE = v.writeregE; writeregM = v.writeregM; writeregW = v.writeregW;
        regwriteE = v.regwriteE; regwriteM = v.regwriteM; regwriteW = v.regwriteW;
        memtoregE = v.memtoregE; memtoregM = v.memtoregM;
        branchD = v.branchD; jrD = v.jrD; mdstartE = v.mdstartE; exceptM = v.exceptM;
    endtask

    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("c%0d.q_underflow", cyc), 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("c%0d.forwardAE", cyc), {6'd0, forwardAE}, {6'd0, e.fae});
            check($sformatf("c%0d.forwardBE", cyc), {6'd0, forwardBE}, {6'd0, e.fbe});
            check($sformatf("c%0d.forwardAD", cyc), {7'd0, forwardAD}, {7'd0, e.fad});
            check($sformatf("c%0d.forwardBD", cyc), {7'd0, forwardBD}, {7'd0, e.fbd});
            check($sformatf("c%0d.stallF", cyc),    {7'd0, stallF},    {7'd0, e.sf});
            check($sformatf("c%0d.stallD", cyc),    {7'd0, stallD},    {7'd0, e.sd});
            check($sformatf("c%0d.stallE", cyc),    {7'd0, stallE},    {7'd0, e.se});
            check($sformatf("c%0d.flushD", cyc),    {7'd0, flushD},    {7'd0, e.fld});
            check($sformatf("c%0d.flushE", cyc),    {7'd0, flushE},    {7'd0, e.fle});
            check($sformatf("c%0d.flushM", cyc),    {7'd0, flushM},    {7'd0, e.flm});
            check($sformatf("c%0d.mdbusy", cyc),    {7'd0, mdbusy},    {7'd0, e.busy});
            check($sformatf("c%0d.mdready", cyc),   {7'd0, mdready},   {7'd0, e.ready});
        end
        cyc++;
    endtask

    // Inputs change 1 time unit after the rising edge (so rst moves between
    // edges); outputs are sampled on the falling edge.
    task automatic step(input in_t v, input logic xb, input logic xr);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(model(v, xb, xr));
        @(negedge clk);
        compare();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;

        // Reset: flushes high, no stalls, forwarding still live, start ignored.
        v = '0; v.rst = 1'b1; v.rsE = 5'd3; v.writeregM = 5'd3; v.regwriteM = 1'b1; v.mdstartE = 1'b1;
        step(v, 1'b0, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);

        // E-stage forwarding: M beats W, r0 never forwards, W-only path.
        v = '0; v.rsE = 5'd3; v.writeregM = 5'd3; v.regwriteM = 1'b1; v.writeregW = 5'd3; v.regwriteW = 1'b1;
        step(v, 1'b0, 1'b0);
        v.rsE = 5'd0; step(v, 1'b0, 1'b0);
        v = '0; v.rsE = 5'd4; v.rtE = 5'd4; v.writeregM = 5'd4; v.writeregW = 5'd4; v.regwriteW = 1'b1;
        step(v, 1'b0, 1'b0);

        // Load-use stall, then the load forwards from M.
        v = '0; v.memtoregE = 1'b1; v.regwriteE = 1'b1; v.writeregE = 5'd5; v.rtD = 5'd5;
        step(v, 1'b0, 1'b0);
        v = '0; v.rtE = 5'd5; v.writeregM = 5'd5; v.regwriteM = 1'b1; v.memtoregM = 1'b1;
        step(v, 1'b0, 1'b0);
        v = '0; v.memtoregE = 1'b1; v.writeregE = 5'd0;
        step(v, 1'b0, 1'b0);

        // Branch on an ALU result in E stalls, then forwards from M.
        v = '0; v.branchD = 1'b1; v.rsD = 5'd7; v.regwriteE = 1'b1; v.writeregE = 5'd7;
        step(v, 1'b0, 1'b0);
        v = '0; v.branchD = 1'b1; v.rsD = 5'd7; v.writeregM = 5'd7; v.regwriteM = 1'b1;
        step(v, 1'b0, 1'b0);
        // jr ignores rt; jr on a load in M stalls; branch rt on load in M stalls.
        v = '0; v.jrD = 1'b1; v.rtD = 5'd9; v.regwriteE = 1'b1; v.writeregE = 5'd9;
        step(v, 1'b0, 1'b0);
        v = '0; v.jrD = 1'b1; v.rsD = 5'd9; v.memtoregM = 1'b1; v.regwriteM = 1'b1; v.writeregM = 5'd9;
        step(v, 1'b0, 1'b0);
        v = '0; v.branchD = 1'b1; v.rtD = 5'd6; v.memtoregM = 1'b1; v.regwriteM = 1'b1; v.writeregM = 5'd6;
        step(v, 1'b0, 1'b0);

        // Mult/div: busy 3 cycles (load-use hazard masked), ready 4th, then idle.
        v = '0; v.mdstartE = 1'b1; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b1, 1'b0);
        v = '0; v.memtoregE = 1'b1; v.writeregE = 5'd5; v.rsD = 5'd5; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b0, 1'b1);
        v = '0; step(v, 1'b0, 1'b0);

        // Exception in the 2nd BUSY cycle: flush all, back to idle, no ready.
        v = '0; v.mdstartE = 1'b1; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b1, 1'b0);
        v = '0; v.exceptM = 1'b1; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);

        // Start squashed by a simultaneous exception never begins.
        v = '0; v.mdstartE = 1'b1; v.exceptM = 1'b1; step(v, 1'b0, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);

        // Asynchronous reset mid-BUSY abandons the op; a new start times normally.
        v = '0; v.mdstartE = 1'b1; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b1, 1'b0);
        v = '0; v.rst = 1'b1; step(v, 1'b0, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);
        v = '0; step(v, 1'b0, 1'b0);
        v = '0; v.mdstartE = 1'b1; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b1, 1'b0);
        v = '0; step(v, 1'b0, 1'b1);
        v = '0; step(v, 1'b0, 1'b0);

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
